// File: rtl/bridge_sched_pkg.sv
// -----------------------------------------------------------------------------
// bridge_sched_pkg
//   Shared constants and types for the External-Bridge-to-Avalon read
//   scheduler. Every file of the scheduler imports this package.
//
//   ADDR_BITS    byte address width of the bridge
//   DATA_BITS    width of one read beat
//   LEN_BITS     width of the per-request beat count
//   NUM_CLIENTS  number of block-read requesters (fixed at 2)
//   BEAT_BYTES   address stride between consecutive beats
// -----------------------------------------------------------------------------
package bridge_sched_pkg;

   localparam int ADDR_BITS   = 26;
   localparam int DATA_BITS   = 128;
   localparam int LEN_BITS    = 10;
   localparam int NUM_CLIENTS = 2;
   localparam int BEAT_BYTES  = DATA_BITS / 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      STEP,
      DONE
   } sched_state_t;

   // Index of a requester; one bit is enough for two clients.
   typedef logic client_id_t;

   // One-hot client vector for a client index.
   function automatic logic [NUM_CLIENTS-1:0] client_onehot(input client_id_t id);
      client_onehot     = '0;
      client_onehot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/bridge_read_scheduler_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way round-robin picker. With a single requester that
//   requester wins; with both requesting, the client that did not win last
//   time wins.
//
//   req    in   2   request per client
//   last   in   1   index of the previous winner
//   grant  out  2   one-hot winner, 0 when nobody requests
// -----------------------------------------------------------------------------
module rr_pick2
   import bridge_sched_pkg::*;
(
   input  logic [1:0] req,
   input  client_id_t last,
   output logic [1:0] grant
);

   // NOTE: every output of a combinational block gets a default first so that
   // no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/bridge_read_scheduler.sv
// -----------------------------------------------------------------------------
// bridge_read_scheduler
//   Shares the single External-Bridge-to-Avalon read port between two
//   block-read requesters (fp_mac weight fetch and image-line fetch). Each
//   granted request reads c_len consecutive 128-bit beats starting at c_addr;
//   every beat is returned on rd_data with a one-cycle rd_valid pulse to the
//   owner, and c_done pulses together with the last beat.
//
//   Optional feature macro: BRIDGE_TIMEOUT_EN
//     defined   - an ack watchdog aborts a beat that waits TIMEOUT_CYC cycles;
//                 the request then finishes with c_done and c_err both high.
//     undefined - ISSUE waits for the ack indefinitely; c_err is always 0.
//
//   clk                    in   system clock
//   reset                  in   asynchronous, active-high
//   c_req                  in   level request per client, held until c_done
//   c_addr                 in   start byte address per client (16-byte aligned)
//   c_len                  in   beats to read per client
//   c_grant                out  one-hot owner of the bridge, 0 when idle
//   rd_valid               out  one-cycle pulse per returned beat, to owner
//   rd_data                out  registered beat data, valid with rd_valid
//   c_done                 out  one-cycle pulse when the owner's request ends
//   c_err                  out  qualifies c_done: request aborted by timeout
//   interface_address      out  bridge byte address
//   interface_byte_enable  out  all ones while interface_read is high
//   interface_read         out  bridge read strobe
//   interface_acknowledge  in   bridge ack, read data valid in the same cycle
//   interface_read_data    in   bridge read data
// -----------------------------------------------------------------------------
module bridge_read_scheduler
   import bridge_sched_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_CLIENTS-1:0]               c_req,
   input  logic [NUM_CLIENTS-1:0][ADDR_BITS-1:0] c_addr,
   input  logic [NUM_CLIENTS-1:0][LEN_BITS-1:0]  c_len,
   output logic [NUM_CLIENTS-1:0]               c_grant,
   output logic [NUM_CLIENTS-1:0]               rd_valid,
   output logic [DATA_BITS-1:0]                 rd_data,
   output logic [NUM_CLIENTS-1:0]               c_done,
   output logic                                 c_err,
   output logic [ADDR_BITS-1:0]                 interface_address,
   output logic [BEAT_BYTES-1:0]                interface_byte_enable,
   output logic                                 interface_read,
   input  logic                                 interface_acknowledge,
   input  logic [DATA_BITS-1:0]                 interface_read_data
);

   sched_state_t           state;
   sched_state_t           next_state;
   client_id_t             owner;
   client_id_t             rr_last;
   logic [LEN_BITS-1:0]    beats_left;
   logic [NUM_CLIENTS-1:0] pick;
   client_id_t             pick_id;
   logic                   beat_ack;
   logic                   last_beat;
   logic                   timeout_hit;

   rr_pick2 u_rr_pick2 (
      .req   (c_req),
      .last  (rr_last),
      .grant (pick)
   );

   assign pick_id = pick[1];

   // An ack only counts while the strobe is actually out on the bridge.
   assign beat_ack  = (state == ISSUE) && interface_read && interface_acknowledge;
   assign last_beat = (beats_left == LEN_BITS'(1));

   assign interface_byte_enable = {BEAT_BYTES{interface_read}};

`ifdef BRIDGE_TIMEOUT_EN
   localparam int TO_BITS = $clog2(TIMEOUT_CYC + 1);

   logic [TO_BITS-1:0] wait_cnt;
   logic               waiting;

   assign waiting     = (state == ISSUE) && interface_read && !interface_acknowledge;
   assign timeout_hit = waiting && (wait_cnt == TO_BITS'(TIMEOUT_CYC - 1));

   // Counts strobe cycles of the current beat; any ack or leaving ISSUE clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (waiting) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end
`else
   logic cfg_unused;

   assign timeout_hit = 1'b0;
   assign cfg_unused  = (TIMEOUT_CYC > 0);
`endif

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the values from before the clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (|c_req) begin
               next_state = (c_len[pick_id] == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (beat_ack) begin
               next_state = last_beat ? DONE : STEP;
            end else if (timeout_hit) begin
               next_state = DONE;
            end
         end
         STEP: begin
            next_state = ISSUE;
         end
         DONE: begin
            // A zero-length request enters DONE without a pulse; it stays one
            // extra cycle to emit c_done before returning to IDLE.
            if (|c_done) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner             <= 1'b0;
         rr_last           <= 1'b1;
         beats_left        <= '0;
         c_grant           <= '0;
         rd_valid          <= '0;
         rd_data           <= '0;
         c_done            <= '0;
         c_err             <= 1'b0;
         interface_address <= '0;
         interface_read    <= 1'b0;
      end else begin
         rd_valid <= '0;
         c_done   <= '0;
         c_err    <= 1'b0;

         // The first ISSUE cycle after a grant is an address setup cycle; after
         // STEP the strobe returns at once, giving exactly one idle cycle
         // between beats.
         interface_read <= (next_state == ISSUE) && (state != IDLE);

         case (state)
            IDLE: begin
               if (|c_req) begin
                  owner             <= pick_id;
                  rr_last           <= pick_id;
                  c_grant           <= pick;
                  interface_address <= c_addr[pick_id];
                  beats_left        <= c_len[pick_id];
               end
            end
            ISSUE: begin
               if (beat_ack) begin
                  rd_data    <= interface_read_data;
                  rd_valid   <= client_onehot(owner);
                  beats_left <= beats_left - 1'b1;
                  if (last_beat) begin
                     c_done <= client_onehot(owner);
                  end
               end else if (timeout_hit) begin
                  c_done <= client_onehot(owner);
                  c_err  <= 1'b1;
               end
            end
            STEP: begin
               // Wraps modulo 2^ADDR_BITS by plain truncation.
               interface_address <= interface_address + ADDR_BITS'(BEAT_BYTES);
            end
            DONE: begin
               if (|c_done) begin
                  c_grant <= '0;
               end else begin
                  c_done <= client_onehot(owner);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bridge_read_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bridge_read_scheduler
//   Directed bench for bridge_read_scheduler. A bridge model acks each read a
//   fixed number of cycles after the strobe rises and returns data derived from
//   the address it saw. Expected beats are queued when a request is driven and
//   compared as rd_valid pulses arrive.
// -----------------------------------------------------------------------------
module tb_bridge_read_scheduler;
   import bridge_sched_pkg::*;

   typedef struct {
      logic [1:0]           who;
      logic [ADDR_BITS-1:0] addr;
      logic                 last;
   } beat_t;

   logic                                  clk = 1'b0;
   logic                                  reset = 1'b1;
   logic [NUM_CLIENTS-1:0]                c_req = '0;
   logic [NUM_CLIENTS-1:0][ADDR_BITS-1:0] c_addr = '0;
   logic [NUM_CLIENTS-1:0][LEN_BITS-1:0]  c_len = '0;
   logic [NUM_CLIENTS-1:0]                c_grant;
   logic [NUM_CLIENTS-1:0]                rd_valid;
   logic [DATA_BITS-1:0]                  rd_data;
   logic [NUM_CLIENTS-1:0]                c_done;
   logic                                  c_err;
   logic [ADDR_BITS-1:0]                  interface_address;
   logic [BEAT_BYTES-1:0]                 interface_byte_enable;
   logic                                  interface_read;
   logic                                  ack = 1'b0;
   logic [DATA_BITS-1:0]                  read_data = '0;

   int    checks = 0;
   int    failures = 0;
   beat_t sb[$];
   bit    ack_enable = 1'b1;
   int    ack_delay = 2;
   int    resp_cnt = 0;
   bit    read_seen = 1'b0;
   bit    prev_read = 1'b0;
   logic [ADDR_BITS-1:0] prev_addr = '0;

   bridge_read_scheduler #(
      .TIMEOUT_CYC (16)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .c_req                 (c_req),
      .c_addr                (c_addr),
      .c_len                 (c_len),
      .c_grant               (c_grant),
      .rd_valid              (rd_valid),
      .rd_data               (rd_data),
      .c_done                (c_done),
      .c_err                 (c_err),
      .interface_address     (interface_address),
      .interface_byte_enable (interface_byte_enable),
      .interface_read        (interface_read),
      .interface_acknowledge (ack),
      .interface_read_data   (read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_BITS-1:0] data_of(input logic [ADDR_BITS-1:0] a);
      return {a ^ 26'h2AAAAAA, 6'h3, ~a, 6'h0, a, 38'h2A_5A5A_5A5A};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input logic [1:0] who, input logic [ADDR_BITS-1:0] addr,
                            input logic last);
      beat_t b;
      b.who  = who;
      b.addr = addr;
      b.last = last;
      sb.push_back(b);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Bridge model: ack ack_delay cycles after the strobe is first seen.
   always @(negedge clk) begin
      if (ack) begin
         ack      = 1'b0;
         resp_cnt = 0;
      end else if (ack_enable && interface_read) begin
         if (resp_cnt == ack_delay) begin
            ack       = 1'b1;
            read_data = data_of(interface_address);
            resp_cnt  = 0;
         end else begin
            resp_cnt++;
         end
      end else begin
         resp_cnt = 0;
      end
   end

   // Monitor: bridge-side invariants every cycle, beat scoreboard on rd_valid.
   always @(negedge clk) begin
      beat_t e;
      if (interface_read) read_seen = 1'b1;
      check("byte_enable", 128'(interface_byte_enable), {128{interface_read}} & 128'hFFFF);
      if (prev_read && interface_read) begin
         check("addr_stable", 128'(interface_address), 128'(prev_addr));
      end
      prev_read = interface_read;
      prev_addr = interface_address;
      if (rd_valid != 2'b00) begin
         if (sb.size() == 0) begin
            check("unexpected_rd_valid", 128'(rd_valid), 128'(0));
         end else begin
            e = sb.pop_front();
            check("beat_owner", 128'(rd_valid), 128'(e.who));
            check("beat_data", rd_data, data_of(e.addr));
            check("beat_grant", 128'(c_grant), 128'(e.who));
            check("beat_done", 128'(c_done), e.last ? 128'(e.who) : 128'(0));
            check("beat_err", 128'(c_err), 128'(0));
         end
      end
   end

   task automatic do_reset(input string tag);
      reset = 1'b1;
      c_req = '0;
      repeat (2) tick();
      check({tag, "_grant"}, 128'(c_grant), 128'(0));
      check({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
      check({tag, "_rd_data"}, rd_data, 128'(0));
      check({tag, "_done"}, 128'(c_done), 128'(0));
      check({tag, "_err"}, 128'(c_err), 128'(0));
      check({tag, "_read"}, 128'(interface_read), 128'(0));
      check({tag, "_addr"}, 128'(interface_address), 128'(0));
      reset = 1'b0;
      tick();
   endtask

   // Requesters drop their level request on seeing their own c_done.
   task automatic serve_all(input string tag, input int budget);
      int n = 0;
      while (c_req != '0 && n < budget) begin
         tick();
         c_req = c_req & ~c_done;
         n++;
      end
      check({tag, "_finished"}, 128'(c_req), 128'(0));
      repeat (2) tick();
      check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
      check({tag, "_grant_idle"}, 128'(c_grant), 128'(0));
   endtask

   initial begin
      int  n;
      bit  found;

      do_reset("rst0");

      // 1: single three-beat burst; address/length changes after grant ignored.
      c_addr[0] = 26'h0000100;
      c_len[0]  = 10'd3;
      c_req     = 2'b01;
      push_beat(2'b01, 26'h0000100, 1'b0);
      push_beat(2'b01, 26'h0000110, 1'b0);
      push_beat(2'b01, 26'h0000120, 1'b1);
      tick();
      check("t1_grant", 128'(c_grant), 128'(2'b01));
      check("t1_read_not_yet", 128'(interface_read), 128'(0));
      c_addr[0] = 26'h0999990;
      c_len[0]  = 10'd7;
      tick();
      check("t1_read_latency", 128'(interface_read), 128'(1));
      check("t1_first_addr", 128'(interface_address), 128'(26'h0000100));
      serve_all("t1", 200);

      // 2: simultaneous requests, fresh round-robin pointer favours client 0.
      do_reset("rst1");
      c_addr[0] = 26'h0001000;
      c_len[0]  = 10'd1;
      c_addr[1] = 26'h0002000;
      c_len[1]  = 10'd2;
      c_req     = 2'b11;
      push_beat(2'b01, 26'h0001000, 1'b1);
      push_beat(2'b10, 26'h0002000, 1'b0);
      push_beat(2'b10, 26'h0002010, 1'b1);
      tick();
      check("t2a_grant", 128'(c_grant), 128'(2'b01));
      serve_all("t2a", 300);

      // Client 0 alone, then both: the pointer now favours client 1.
      c_addr[0] = 26'h0003000;
      c_len[0]  = 10'd1;
      c_req     = 2'b01;
      push_beat(2'b01, 26'h0003000, 1'b1);
      serve_all("t2b", 100);
      c_addr[0] = 26'h0003100;
      c_addr[1] = 26'h0003200;
      c_len[1]  = 10'd1;
      c_req     = 2'b11;
      push_beat(2'b10, 26'h0003200, 1'b1);
      push_beat(2'b01, 26'h0003100, 1'b1);
      tick();
      check("t2c_grant", 128'(c_grant), 128'(2'b10));
      serve_all("t2c", 300);

      // 3: zero-length request finishes with no bridge cycle.
      read_seen = 1'b0;
      c_len[1]  = 10'd0;
      c_req     = 2'b10;
      tick();
      check("t3_grant", 128'(c_grant), 128'(2'b10));
      check("t3_done_early", 128'(c_done), 128'(0));
      tick();
      check("t3_done", 128'(c_done), 128'(2'b10));
      check("t3_err", 128'(c_err), 128'(0));
      c_req = 2'b00;
      tick();
      check("t3_grant_clear", 128'(c_grant), 128'(0));
      repeat (3) tick();
      check("t3_no_read", 128'(read_seen), 128'(0));

      // 4: address wraps past the top of the 26-bit space.
      c_addr[0] = 26'h3FFFFF0;
      c_len[0]  = 10'd2;
      c_req     = 2'b01;
      push_beat(2'b01, 26'h3FFFFF0, 1'b0);
      push_beat(2'b01, 26'h0000000, 1'b1);
      serve_all("t4", 200);

      // 5: reset during the strobe of beat 2 of 4.
      c_addr[0] = 26'h0004000;
      c_len[0]  = 10'd4;
      c_req     = 2'b01;
      push_beat(2'b01, 26'h0004000, 1'b0);
      found = 1'b0;
      n     = 0;
      while (!found && n < 100) begin
         tick();
         found = interface_read && (interface_address == 26'h0004010);
         n++;
      end
      check("t5_reached_beat2", 128'(found), 128'(1));
      reset = 1'b1;
      c_req = 2'b00;
      #1;
      check("t5_read_dropped", 128'(interface_read), 128'(0));
      check("t5_grant", 128'(c_grant), 128'(0));
      check("t5_addr", 128'(interface_address), 128'(0));
      check("t5_rd_data", rd_data, 128'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_no_done", 128'(c_done), 128'(0));
         check("t5_no_valid", 128'(rd_valid), 128'(0));
      end
      reset = 1'b0;
      tick();
      check("t5_sb_empty", 128'(sb.size()), 128'(0));

`ifdef BRIDGE_TIMEOUT_EN
      // 6: ack withheld, watchdog aborts after 16 strobe cycles.
      ack_enable = 1'b0;
      c_addr[0]  = 26'h0000500;
      c_len[0]   = 10'd2;
      c_req      = 2'b01;
      n = 0;
      while (!interface_read && n < 20) begin
         tick();
         n++;
      end
      check("t6_read_up", 128'(interface_read), 128'(1));
      n = 0;
      while (interface_read && n < 100) begin
         n++;
         tick();
      end
      check("t6_strobe_cycles", 128'(n), 128'(16));
      check("t6_done", 128'(c_done), 128'(2'b01));
      check("t6_err", 128'(c_err), 128'(1));
      c_req      = 2'b00;
      ack_enable = 1'b1;
      repeat (2) tick();
      c_addr[0] = 26'h0000600;
      c_len[0]  = 10'd1;
      c_req     = 2'b01;
      push_beat(2'b01, 26'h0000600, 1'b1);
      serve_all("t6_after", 100);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
